// File: rtl/dist_pkg.sv
// Shared definitions for the distance datapath: sequencer state encoding and
// the {cs, we, oe, sel} BRAM flag layout.
package dist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_A    = 3'd1,
    ST_RD_B    = 3'd2,
    ST_CAP_B   = 3'd3,
    ST_PRESENT = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  // Bit positions inside FLAG_Bram.
  localparam int FLAG_CS  = 3;
  localparam int FLAG_WE  = 2;
  localparam int FLAG_OE  = 1;
  localparam int FLAG_SEL = 0;

  localparam logic [3:0] FLAG_IDLE    = 4'b0000;
  localparam logic [3:0] FLAG_RD_VEC0 = 4'((1 << FLAG_CS) | (1 << FLAG_OE));
  localparam logic [3:0] FLAG_RD_VEC1 = FLAG_RD_VEC0 | 4'(1 << FLAG_SEL);

endpackage

// File: rtl/vec_fetch_sequencer_if.sv
// BRAM read port and operand-pair handshake between the fetch sequencer
// (master) and the BRAM / subtract-square pipe (slave).
interface vec_fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] ADDR_Bram;
  logic [3:0]        FLAG_Bram;
  logic [DATA_W-1:0] DIN_Bram;
  logic              EN_Pipe;
  logic              RDY_Pipe;
  logic [DATA_W-1:0] A_Pipe;
  logic [DATA_W-1:0] B_Pipe;
  logic              LAST_Pipe;

  modport master (
    output ADDR_Bram, FLAG_Bram, EN_Pipe, A_Pipe, B_Pipe, LAST_Pipe,
    input  DIN_Bram, RDY_Pipe
  );

  modport slave (
    input  ADDR_Bram, FLAG_Bram, EN_Pipe, A_Pipe, B_Pipe, LAST_Pipe,
    output DIN_Bram, RDY_Pipe
  );

endinterface

// File: rtl/vec_fetch_sequencer.sv
// Fetches vec0/vec1 element pairs from BRAM and hands them to the pipe.
// Optional macro VEC_FETCH_ERR_EN adds an ERR output for out-of-range vectors.
module vec_fetch_sequencer
  import dist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [7:0]        VECTOR_WIDTH,
  output logic              BUSY,
  output logic              DONE,
`ifdef VEC_FETCH_ERR_EN
  output logic              ERR,
`endif
  vec_fetch_sequencer_if.master bus
);

  state_t            state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [7:0]        width_reg;
  logic [7:0]        idx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        flag_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              en_reg;
  logic              last_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [7:0]        idx_next;
  logic              start_skip;

  assign idx_next = idx_reg + 8'd1;

`ifdef VEC_FETCH_ERR_EN
  // Extra headroom so base+width cannot overflow the comparison itself.
  localparam int SPAN_W = ADDR_W + 9;
  logic [SPAN_W-1:0] span;
  logic              overflow;
  logic              err_reg;

  assign span       = SPAN_W'(BASE_ADDR) + SPAN_W'(VECTOR_WIDTH);
  assign overflow   = span > (SPAN_W'(1) << ADDR_W);
  assign start_skip = (VECTOR_WIDTH == 8'd0) || overflow;
  assign ERR        = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && START) begin
      err_reg <= overflow;
    end
  end
`else
  assign start_skip = (VECTOR_WIDTH == 8'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      base_reg  <= '0;
      width_reg <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      flag_reg  <= FLAG_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      en_reg    <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          idx_reg  <= '0;
          flag_reg <= FLAG_IDLE;
          en_reg   <= 1'b0;
          last_reg <= 1'b0;
          done_reg <= 1'b0;
          if (START) begin
            base_reg  <= BASE_ADDR;
            width_reg <= VECTOR_WIDTH;
            busy_reg  <= 1'b1;
            if (start_skip) begin
              state_reg <= ST_FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RD_A;
              addr_reg  <= BASE_ADDR;
              flag_reg  <= FLAG_RD_VEC0;
            end
          end
        end
        ST_RD_A: begin
          state_reg <= ST_RD_B;
          flag_reg  <= FLAG_RD_VEC1;
        end
        ST_RD_B: begin
          // DIN now carries the vec0 word addressed in RD_A.
          a_reg     <= bus.DIN_Bram;
          state_reg <= ST_CAP_B;
          flag_reg  <= FLAG_IDLE;
        end
        ST_CAP_B: begin
          b_reg     <= bus.DIN_Bram;
          state_reg <= ST_PRESENT;
          en_reg    <= 1'b1;
          last_reg  <= (idx_reg == width_reg - 8'd1);
        end
        ST_PRESENT: begin
          if (bus.RDY_Pipe) begin
            en_reg   <= 1'b0;
            last_reg <= 1'b0;
            idx_reg  <= idx_next;
            if (last_reg) begin
              state_reg <= ST_FIN;
              done_reg  <= 1'b1;
              addr_reg  <= '0;
            end else begin
              state_reg <= ST_RD_A;
              addr_reg  <= base_reg + ADDR_W'(idx_next);
              flag_reg  <= FLAG_RD_VEC0;
            end
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          idx_reg   <= '0;
          addr_reg  <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
          flag_reg  <= FLAG_IDLE;
          en_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ADDR_Bram = addr_reg;
  assign bus.FLAG_Bram = flag_reg;
  assign bus.EN_Pipe   = en_reg;
  assign bus.A_Pipe    = a_reg;
  assign bus.B_Pipe    = b_reg;
  assign bus.LAST_Pipe = last_reg;
  assign BUSY          = busy_reg;
  assign DONE          = done_reg;

endmodule

// File: tb/tb_vec_fetch_sequencer.sv
// Scoreboard bench for vec_fetch_sequencer: a two-bank BRAM model feeds the
// DUT, expected reads/pairs/DONE timing are queued per vector and retired as seen.
`timescale 1ns/1ps
module tb_vec_fetch_sequencer;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] flag;
  } rd_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] vector_width;
  logic       busy;
  logic       done;
`ifdef VEC_FETCH_ERR_EN
  logic       err;
`endif

  vec_fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  vec_fetch_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .START        (start),
    .BASE_ADDR    (base_addr),
    .VECTOR_WIDTH (vector_width),
    .BUSY         (busy),
    .DONE         (done),
`ifdef VEC_FETCH_ERR_EN
    .ERR          (err),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    edges  = 0;
  int    t0     = 0;
  int    exp_done   = 0;
  int    done_cnt   = 0;
  int    pair_idx   = 0;
  int    stall_elem = 0;
  int    stall_left = 0;
  bit    run_active = 1'b0;
  bit    exp_err    = 1'b0;
  rd_t   reads_q[$];
  pair_t pairs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] vec0_word(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  function automatic logic [7:0] vec1_word(input logic [7:0] a);
    return 8'(a * 8'd7 + 8'd3);
  endfunction

  always @(posedge clk) edges++;

  // BRAM model: registered read, bank chosen by sel.
  always @(posedge clk) begin
    if (bus.FLAG_Bram[3])
      bus.DIN_Bram <= bus.FLAG_Bram[0] ? vec1_word(bus.ADDR_Bram) : vec0_word(bus.ADDR_Bram);
    else
      bus.DIN_Bram <= 8'h00;
  end

  // Pipe-side driver and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    int    cyc;
    rd_t   er;
    pair_t ep;
    if (!rst) begin
      cyc = edges - t0;
      if (bus.EN_Pipe && stall_left > 0 && pair_idx == stall_elem) begin
        bus.RDY_Pipe = 1'b0;
        stall_left--;
      end else begin
        bus.RDY_Pipe = 1'b1;
      end

      if (bus.FLAG_Bram[3]) begin
        if (reads_q.size() == 0) begin
          check("rd_extra", {24'd0, bus.ADDR_Bram}, 32'hFFFF_FFFF);
        end else begin
          er = reads_q.pop_front();
          check("rd_addr", {24'd0, bus.ADDR_Bram}, {24'd0, er.addr});
          check("rd_flag", {28'd0, bus.FLAG_Bram}, {28'd0, er.flag});
        end
      end else begin
        check("flag_idle", {28'd0, bus.FLAG_Bram}, 32'd0);
      end

      if (bus.EN_Pipe) begin
        if (pairs_q.size() == 0) begin
          check("pair_extra", 32'd1, 32'd0);
        end else begin
          ep = pairs_q[0];
          check("pipe_a", {24'd0, bus.A_Pipe}, {24'd0, ep.a});
          check("pipe_b", {24'd0, bus.B_Pipe}, {24'd0, ep.b});
          check("pipe_last", {31'd0, bus.LAST_Pipe}, {31'd0, ep.last});
          if (bus.RDY_Pipe) begin
            $display("pair %0d a=%02h b=%02h last=%0b cycle=%0d",
                     pair_idx, bus.A_Pipe, bus.B_Pipe, bus.LAST_Pipe, cyc);
            void'(pairs_q.pop_front());
            pair_idx++;
          end
        end
      end

      if (run_active)
        check("busy", {31'd0, busy}, {31'd0, (cyc >= 1 && cyc <= exp_done)});

      if (done) begin
        done_cnt++;
        if (run_active) check("done_cycle", cyc, exp_done);
        else            check("done_spurious", 32'd1, 32'd0);
      end
    end
  end

  task automatic run_vec(input logic [7:0] b, input logic [7:0] w,
                         input int s_elem, input int s_len, input bit restart);
    bit ovf;
    logic [7:0] a8;
    @(posedge clk); #1;
    ovf = 1'b0;
`ifdef VEC_FETCH_ERR_EN
    ovf = (int'(b) + int'(w)) > 256;
`endif
    exp_err = ovf;
    if (!ovf) begin
      for (int i = 0; i < int'(w); i++) begin
        a8 = 8'(int'(b) + i);
        reads_q.push_back('{addr: a8, flag: 4'b1010});
        reads_q.push_back('{addr: a8, flag: 4'b1011});
        pairs_q.push_back('{a: vec0_word(a8), b: vec1_word(a8), last: (i == int'(w) - 1)});
      end
    end
    if (ovf || w == 8'd0) exp_done = 1;
    else exp_done = 4 * int'(w) + 1 + ((s_elem < int'(w)) ? s_len : 0);
    stall_elem = s_elem;
    stall_left = s_len;
    pair_idx   = 0;
    done_cnt   = 0;
    t0         = edges;
    run_active = 1'b1;
    start        = 1'b1;
    base_addr    = b;
    vector_width = w;
    @(posedge clk); #1;
    start        = 1'b0;
    base_addr    = ~b;
    vector_width = 8'hFF;
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      start = (restart && (edges - t0) == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_cnt, 32'd1);
    check("reads_left", reads_q.size(), 32'd0);
    check("pairs_left", pairs_q.size(), 32'd0);
`ifdef VEC_FETCH_ERR_EN
    check("err", {31'd0, err}, {31'd0, exp_err});
`endif
    $display("vector base=%02h width=%0d stall=%0d restart=%0b done_cycle=%0d pairs=%0d",
             b, w, s_len, restart, exp_done, pair_idx);
    run_active = 1'b0;
    reads_q.delete();
    pairs_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, {24'd0, bus.ADDR_Bram}, 32'd0);
    check({tag, "_flag"}, {28'd0, bus.FLAG_Bram}, 32'd0);
    check({tag, "_en"}, {31'd0, bus.EN_Pipe}, 32'd0);
    check({tag, "_a"}, {24'd0, bus.A_Pipe}, 32'd0);
    check({tag, "_b"}, {24'd0, bus.B_Pipe}, 32'd0);
    check({tag, "_last"}, {31'd0, bus.LAST_Pipe}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic abort_run();
    logic [7:0] a8;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(8'h20 + i);
      reads_q.push_back('{addr: a8, flag: 4'b1010});
      reads_q.push_back('{addr: a8, flag: 4'b1011});
      pairs_q.push_back('{a: vec0_word(a8), b: vec1_word(a8), last: (i == 2)});
    end
    exp_done   = 13;
    stall_left = 0;
    pair_idx   = 0;
    done_cnt   = 0;
    t0         = edges;
    run_active = 1'b1;
    start = 1'b1; base_addr = 8'h20; vector_width = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && (edges - t0) < 6; k++) begin
      @(posedge clk); #1;
    end
    check("abort_pairs_seen", pair_idx, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    run_active = 1'b0;
    reads_q.delete();
    pairs_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 32'd0);
    $display("abort during element 1 RD_B, idle for 20 cycles");
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = 8'h00;
    vector_width = 8'h00;
    bus.RDY_Pipe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
`ifdef VEC_FETCH_ERR_EN
    check("reset_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;

    run_vec(8'h10, 8'd3, 99, 0, 1'b0);   // basic, DONE in cycle 13
    run_vec(8'h10, 8'd3, 1, 5, 1'b0);    // 5 stall cycles on element 1, DONE in 18
    run_vec(8'h40, 8'd0, 99, 0, 1'b0);   // empty vector
    run_vec(8'hFE, 8'd3, 99, 0, 1'b0);   // wraps, or ERR when enabled
    run_vec(8'hFD, 8'd3, 99, 0, 1'b0);   // ends exactly at the top of the space
    run_vec(8'h33, 8'd1, 0, 2, 1'b0);    // single element with stall
    abort_run();
    run_vec(8'h20, 8'd3, 99, 0, 1'b0);   // clean restart after abort
    run_vec(8'h50, 8'd4, 99, 0, 1'b1);   // START re-pulsed while busy

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
